m_dmem_arbiter: RTL

Two-port arbiter that shares the single-port data memory (`m_data_mem`: combinational read, write on rising clock edge) between the processor load/store port (port A) and a DMA/debug loader port (port B). Ownership is registered. Arbitration is round-robin, with a bounded hold count and an atomic lock. Read data returns one cycle after the access. The block sits between `processor`/loader and `m_data_mem` inside `m_top`, and its grant signals drive the processor stall.

---
 rtl/m_dmem_arbiter_if.sv | 44 ++++
 rtl/m_dmem_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/m_dmem_arbiter_if.sv
// Bus bundle between the two requesters (processor port A, loader port B),
// the arbiter and the single-port data memory.
interface m_dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_a_req;
    logic          i_b_req;
    logic          i_a_we;
    logic          i_b_we;
    logic          i_a_lock;
    logic          i_b_lock;
    logic [AW-1:0] i_a_addr;
    logic [AW-1:0] i_b_addr;
    logic [DW-1:0] i_a_wdata;
    logic [DW-1:0] i_b_wdata;
    logic          o_a_gnt;
    logic          o_b_gnt;
    logic [DW-1:0] o_a_rdata;
    logic [DW-1:0] o_b_rdata;
    logic          o_a_rvalid;
    logic          o_b_rvalid;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wd;
    logic [DW-1:0] i_mem_rd;
    logic          o_busy;

    // Arbiter side
    modport slave (
        input  i_a_req, i_b_req, i_a_we, i_b_we, i_a_lock, i_b_lock,
        input  i_a_addr, i_b_addr, i_a_wdata, i_b_wdata, i_mem_rd,
        output o_a_gnt, o_b_gnt, o_a_rdata, o_b_rdata, o_a_rvalid, o_b_rvalid,
        output o_mem_we, o_mem_addr, o_mem_wd, o_busy
    );

    // Requester / memory side
    modport master (
        output i_a_req, i_b_req, i_a_we, i_b_we, i_a_lock, i_b_lock,
        output i_a_addr, i_b_addr, i_a_wdata, i_b_wdata, i_mem_rd,
        input  o_a_gnt, o_b_gnt, o_a_rdata, o_b_rdata, o_a_rvalid, o_b_rvalid,
        input  o_mem_we, o_mem_addr, o_mem_wd, o_busy
    );
endinterface

// File: rtl/m_dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the
// processor load/store port (A) and the DMA/debug loader port (B).
//
//   state     | meaning
//   ----------+----------------------------------------------
//   OWN_NONE  | nobody owns the memory; mux drives zeros
//   OWN_A     | port A owns the memory, o_a_gnt high
//   OWN_B     | port B owns the memory, o_b_gnt high
module m_dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    m_dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_e;

    localparam logic [4:0] MAX_HOLD_C = 5'(MAX_HOLD);

    logic [1:0]    rst_sync_q;
    logic          rst_n_int;
    owner_e        owner_q, owner_d;
    logic          last_b_q, last_b_d;
    logic [3:0]    hold_q, hold_d;
    logic [DW-1:0] a_rdata_q, b_rdata_q;
    logic          a_rvalid_q, b_rvalid_q;

    logic          txn_a, txn_b;
    logic          own_req, own_lock, oth_req;
    logic          hold_ok;

    // Reset asserts immediately, releases two clocks after i_reset_n rises
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) rst_sync_q <= 2'b00;
        else            rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n_int = rst_sync_q[1];

    assign txn_a = (owner_q == OWN_A) && bus.i_a_req;
    assign txn_b = (owner_q == OWN_B) && bus.i_b_req;

    // Ownership, round-robin pointer and hold counter state registers
    always_ff @(posedge i_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            owner_q  <= OWN_NONE;
            last_b_q <= 1'b1;
            hold_q   <= 4'd0;
        end else begin
            owner_q  <= owner_d;
            last_b_q <= last_b_d;
            hold_q   <= hold_d;
        end
    end

    // Next owner: lock, then keep-while-alone, then hold budget, then round-robin
    always_comb begin
        owner_d  = owner_q;
        last_b_d = last_b_q;
        hold_d   = hold_q;
        own_req  = 1'b0;
        own_lock = 1'b0;
        oth_req  = 1'b0;

        case (owner_q)
            OWN_A: begin
                own_req  = bus.i_a_req;
                own_lock = bus.i_a_lock;
                oth_req  = bus.i_b_req;
            end
            OWN_B: begin
                own_req  = bus.i_b_req;
                own_lock = bus.i_b_lock;
                oth_req  = bus.i_a_req;
            end
            default: ;
        endcase

        hold_ok = ({1'b0, hold_q} + 5'd1) < MAX_HOLD_C;

        if ((owner_q != OWN_NONE) && own_req && (own_lock || !oth_req || hold_ok))
            owner_d = owner_q;
        else if (bus.i_a_req && !bus.i_b_req)
            owner_d = OWN_A;
        else if (bus.i_b_req && !bus.i_a_req)
            owner_d = OWN_B;
        else if (bus.i_a_req && bus.i_b_req)
            owner_d = last_b_q ? OWN_A : OWN_B;
        else
            owner_d = OWN_NONE;

        if (txn_a) last_b_d = 1'b0;
        if (txn_b) last_b_d = 1'b1;

        // Saturate so a long locked burst cannot wrap the count back into budget
        if ((owner_d != owner_q) || !oth_req)
            hold_d = 4'd0;
        else if ((txn_a || txn_b) && (hold_q != 4'hF))
            hold_d = hold_q + 4'd1;
    end

    // Memory mux: owner's qualifiers to the memory, zeros when idle
    always_comb begin
        bus.o_mem_we   = 1'b0;
        bus.o_mem_addr = '0;
        bus.o_mem_wd   = '0;
        case (owner_q)
            OWN_A: begin
                bus.o_mem_we   = bus.i_a_req && bus.i_a_we;
                bus.o_mem_addr = bus.i_a_addr;
                bus.o_mem_wd   = bus.i_a_wdata;
            end
            OWN_B: begin
                bus.o_mem_we   = bus.i_b_req && bus.i_b_we;
                bus.o_mem_addr = bus.i_b_addr;
                bus.o_mem_wd   = bus.i_b_wdata;
            end
            default: ;
        endcase
    end

    // Read capture: memory read data registered into the reading port
    always_ff @(posedge i_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            a_rvalid_q <= txn_a && !bus.i_a_we;
            b_rvalid_q <= txn_b && !bus.i_b_we;
            if (txn_a && !bus.i_a_we) a_rdata_q <= bus.i_mem_rd;
            if (txn_b && !bus.i_b_we) b_rdata_q <= bus.i_mem_rd;
        end
    end

    assign bus.o_a_gnt    = (owner_q == OWN_A);
    assign bus.o_b_gnt    = (owner_q == OWN_B);
    assign bus.o_busy     = (owner_q != OWN_NONE);
    assign bus.o_a_rdata  = a_rdata_q;
    assign bus.o_b_rdata  = b_rdata_q;
    assign bus.o_a_rvalid = a_rvalid_q;
    assign bus.o_b_rvalid = b_rvalid_q;
endmodule
